// File: rtl/template_match_scorer.sv
// rtl/template_match_scorer.sv - scores a 16x16 canvas sample against a template row by row
// Rows are XNORed into a stage-1 register, then popcounted into the accumulator on the next edge.
module template_match_scorer #(
    parameter logic [8:0] THRESH = 9'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  rom_addr,
    input  logic [0:15] rom_char,
    output logic [3:0]  can_addr,
    input  logic [0:15] can_row,
    output logic        busy,
    output logic        done,
    output logic [8:0]  score,
    output logic        match
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [8:0]  acc_q, acc_d;
    logic [0:15] stage_q, stage_d;
    logic [8:0]  score_q, score_d;
    logic        match_q, match_d;

    logic [4:0]  pop;
    logic [8:0]  sum;

    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + {4'd0, stage_q[i]};
        end
    end

    assign sum = acc_q + {4'd0, pop};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        acc_d   = acc_q;
        stage_d = stage_q;
        score_d = score_q;
        match_d = match_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    row_d   = 4'd0;
                    acc_d   = 9'd0;
                end
            end
            S_SCAN: begin
                stage_d = ~(rom_char ^ can_row);
                row_d   = row_q + 4'd1;
                // stage_q holds no captured row yet on the first scan edge
                if (row_q != 4'd0) begin
                    acc_d = sum;
                end
                if (row_q == 4'd15) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                acc_d   = sum;
                score_d = sum;
                match_d = (sum >= THRESH);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 4'd0;
            acc_q   <= 9'd0;
            stage_q <= '0;
            score_q <= 9'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            stage_q <= stage_d;
            score_q <= score_d;
            match_q <= match_d;
        end
    end

    assign rom_addr = row_q;
    assign can_addr = row_q;
    assign busy     = (state_q == S_SCAN) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign score    = score_q;
    assign match    = match_q;

endmodule

// File: tb/tb_template_match_scorer.sv
// tb/tb_template_match_scorer.sv - self-checking bench for template_match_scorer
module tb_template_match_scorer;

    localparam logic [8:0] THR = 9'd200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  rom_addr, can_addr;
    logic [0:15] rom_char, can_row;
    logic        busy, done;
    logic [8:0]  score;
    logic        match;

    logic [15:0] rom_mem [16];
    logic [15:0] can_mem [16];

    int checks = 0;
    int failures = 0;

    // Model: cycles since an accepted start (0 = idle, 1..17 busy, 18 = done cycle)
    int         exp_cnt = 0;
    int         pend_score = 0;
    logic [8:0] exp_score = 9'd0;
    logic       exp_match = 1'b0;

    template_match_scorer #(.THRESH(THR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_char (rom_char),
        .can_addr (can_addr),
        .can_row  (can_row),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .match    (match)
    );

    assign rom_char = rom_mem[rom_addr];
    assign can_row  = can_mem[can_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_score();
        int s = 0;
        for (int r = 0; r < 16; r++) begin
            s += $countones(~(rom_mem[r] ^ can_mem[r]));
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt   <= 0;
            exp_score <= 9'd0;
            exp_match <= 1'b0;
        end else if (exp_cnt == 0) begin
            if (start) begin
                exp_cnt    <= 1;
                pend_score <= ref_score();
            end
        end else if (exp_cnt == 18) begin
            exp_cnt <= 0;
        end else begin
            exp_cnt <= exp_cnt + 1;
            if (exp_cnt == 17) begin
                exp_score <= pend_score[8:0];
                exp_match <= (pend_score >= int'(THR));
            end
        end
    end

    always @(negedge clk) begin
        int ea;
        ea = (exp_cnt >= 1 && exp_cnt <= 16) ? exp_cnt - 1 : 0;
        chk("busy", busy, (exp_cnt >= 1 && exp_cnt <= 17));
        chk("done", done, (exp_cnt == 18));
        chk("score", score, exp_score);
        chk("match", match, exp_match);
        chk("rom_addr", rom_addr, ea);
        chk("can_addr", can_addr, ea);
    end

    task automatic set_diff(input int n);
        for (int r = 0; r < 16; r++) begin
            rom_mem[r] = 16'($urandom);
            can_mem[r] = rom_mem[r];
        end
        for (int i = 0; i < n; i++) begin
            can_mem[i / 16][i % 16] = ~can_mem[i / 16][i % 16];
        end
    endtask

    task automatic randomize_mem();
        int mode;
        mode = $urandom_range(0, 2);
        for (int r = 0; r < 16; r++) begin
            rom_mem[r] = 16'($urandom);
            case (mode)
                0: can_mem[r] = 16'($urandom);
                1: can_mem[r] = rom_mem[r] ^ 16'($urandom & $urandom & $urandom & $urandom);
                default: can_mem[r] = rom_mem[r] ^ 16'($urandom & $urandom);
            endcase
        end
    endtask

    // Called at a negedge; pulses start for one edge and returns negedges until done.
    task automatic run_scan(output int lat);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
        end while (!done && lat < 40);
        @(negedge clk);
    endtask

    initial begin
        int lat, ndone, seq_ok, d1, d2;
        for (int r = 0; r < 16; r++) begin
            rom_mem[r] = 16'hFFFF;
            can_mem[r] = 16'hFFFF;
        end
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_score", score, 0);
        chk("reset_addr", rom_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(lat);
        chk("all_ones_latency", lat, 18);
        chk("all_ones_score", score, 256);
        chk("all_ones_match", match, 1);

        for (int r = 0; r < 16; r++) begin
            rom_mem[r] = 16'($urandom);
            can_mem[r] = ~rom_mem[r];
        end
        run_scan(lat);
        chk("inverse_latency", lat, 18);
        chk("inverse_score", score, 0);
        chk("inverse_match", match, 0);

        set_diff(56);
        run_scan(lat);
        chk("diff56_score", score, 200);
        chk("diff56_match", match, 1);

        set_diff(57);
        run_scan(lat);
        chk("diff57_score", score, 199);
        chk("diff57_match", match, 0);

        // Restart attempts at E5 and E16 must be ignored
        set_diff(20);
        start = 1'b1;
        ndone = 0;
        seq_ok = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 16);
            if (k <= 16 && rom_addr == 4'(k - 1)) seq_ok++;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("repulse_done_count", ndone, 1);
        chk("repulse_addr_seq", seq_ok, 16);
        chk("repulse_score", score, 236);

        // Reset right after E9 aborts the scan
        set_diff(56);
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_score", score, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_scan(lat);
        chk("after_abort_latency", lat, 18);
        chk("after_abort_score", score, 200);

        // start held high for 40 edges
        for (int r = 0; r < 16; r++) begin
            rom_mem[r] = 16'hFFFF;
            can_mem[r] = 16'hFFFF;
        end
        start = 1'b1;
        ndone = 0;
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = k;
                if (ndone == 2) d2 = k;
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone, 2);
        chk("held_first_done", d1, 18);
        chk("held_spacing", d2 - d1, 19);
        lat = 0;
        while (exp_cnt != 0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("held_drain_timeout", (lat < 40), 1);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (exp_cnt == 0 && $urandom_range(0, 2) == 0) randomize_mem();
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/template_match_scorer.md
TEMPLATE_MATCH_SCORER -- requirements
Module: template_match_scorer

Interface
REQ-001 SHALL have parameter THRESH, default 9'd200, meaning minimum score for match=1.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to score one 16x16 sample against the template.
REQ-005 SHALL have port rom_addr  output  4  template row index to the digit bitmap ROM.
REQ-006 SHALL have port rom_char  input  16 [0:15]  template row from ROM, combinational for rom_addr.
REQ-007 SHALL have port can_addr  output  4  sample row index to the drawing canvas memory.
REQ-008 SHALL have port can_row  input  16 [0:15]  sample row from canvas, combinational for can_addr.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when score/match are updated.
REQ-011 SHALL have port score  output  9  count of matching pixels, 0..256.
REQ-012 SHALL have port match  output  1  score >= THRESH.

Function
REQ-013 SHALL implement states IDLE, SCAN, FLUSH, DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge (E0), enter SCAN with row counter=0 and internal accumulator=0.
REQ-015 SHALL drive rom_addr = can_addr = row counter at all times; both equal 0 outside SCAN.
REQ-016 SHALL, in SCAN, register stage-1 vector = XNOR(rom_char, can_row) at each edge, then increment row counter.
REQ-017 SHALL leave SCAN for FLUSH on the edge that captures row 15 (E16); row counter wraps to 0, no row 16 is read.
REQ-018 SHALL add popcount (0..16) of the stage-1 vector to the accumulator on every edge one cycle after that vector's capture (E2..E17).
REQ-019 SHALL leave FLUSH for DONE at E17, loading score with the final accumulator and match with (final >= THRESH) on that edge.
REQ-020 SHALL hold done=1 exactly during the DONE cycle (after E17), then return to IDLE at E18.
REQ-021 SHALL hold busy=1 in SCAN and FLUSH (after E0 through E17), 0 in IDLE and DONE.
REQ-022 SHALL keep score and match unchanged from a DONE load until the next DONE load.
REQ-023 SHALL ignore start while in SCAN, FLUSH or DONE; no restart, no queueing.
REQ-024 SHALL accept start sampled in IDLE only; start held high continuously yields back-to-back scans with one IDLE cycle between DONE and next SCAN.
REQ-025 SHALL use a 9-bit accumulator; max 256 SHALL be representable without overflow.
REQ-026 SHALL compare score and THRESH as unsigned 9-bit values.
REQ-027 SHALL treat pixel bit index 0 of rom_char and can_row as the same column; no bit reordering.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, row counter 0, accumulator 0, stage-1 vector 0, busy 0, done 0, score 0, match 0, independent of clk.
REQ-029 SHALL abort any scan in progress on rst_n assertion with no done pulse and score not updated from partial data.
REQ-030 SHALL resume operation on the first rising clk edge after rst_n deasserts; start on that edge is accepted.

Verification
REQ-031 SHALL cover: model ROM all rows 16'hFFFF, canvas all 16'hFFFF, start pulse at E0 -> busy E0..E17, done pulse after E17, score=256, match=1.
REQ-032 SHALL cover: canvas row = bitwise inverse of template row for all 16 rows -> score=0, match=0, done after E17.
REQ-033 SHALL cover: identical template/canvas except 56 differing pixels, THRESH=200 -> score=200, match=1; with 57 differing -> score=199, match=0.
REQ-034 SHALL cover: start re-pulsed at E5 and E16 during a scan -> single done pulse, score unaffected, rom_addr sequence 0..15 exactly once.
REQ-035 SHALL cover: rst_n low at E9 mid-scan -> immediately busy=0, score=0, rom_addr=0, no done; new start after release -> correct full score.
REQ-036 SHALL cover: start held high 40 cycles -> two complete scans, done pulses 19 cycles apart, rom_addr always within 0..15.
